// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch unit (master) and its environment: run control,
// instruction memory read port, branch redirect and the ready/valid output stream.
interface instruction_fetch_if;
  logic        run;
  logic [6:0]  program_length;
  logic        mem_clk_enable;
  logic [5:0]  mem_read_address;
  logic [15:0] mem_instruction;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic [15:0] instr_out;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;

  modport master (
    input  run, program_length, mem_instruction, branch_taken, branch_target, instr_ready,
    output mem_clk_enable, mem_read_address, instr_out, instr_pc, instr_valid, done
  );

  modport slave (
    output run, program_length, mem_instruction, branch_taken, branch_target, instr_ready,
    input  mem_clk_enable, mem_read_address, instr_out, instr_pc, instr_valid, done
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential reads from a one-cycle-latency instruction memory,
// delivered through a 2-entry ready/valid buffer with branch redirect and flush.
module instruction_fetch (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [6:0]  r_pc;
  logic [6:0]  r_length;
  logic        r_inflight;
  logic [5:0]  r_inflight_pc;
  logic [1:0]  r_count;
  logic [15:0] r_head_data;
  logic [15:0] r_tail_data;
  logic [5:0]  r_head_pc;
  logic [5:0]  r_tail_pc;

  logic        w_fetching;
  logic        w_branch;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_drained;
  logic [2:0]  w_occupancy;

  // The strobe must see this cycle's pop and branch, so it is decoded from registers plus inputs.
  always_comb begin
    w_fetching  = (r_state == ST_FETCH);
    w_branch    = w_fetching & bus.branch_taken;
    w_pop       = (r_count != 2'd0) & bus.instr_ready;
    w_push      = r_inflight & ~w_branch;
    w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue     = w_fetching & bus.run & (r_pc < r_length) & ~bus.branch_taken
                  & (w_occupancy < 3'd2);
    w_drained   = (r_pc >= r_length) & (r_count == 2'd0) & ~r_inflight;
  end

  assign bus.mem_clk_enable   = w_issue;
  assign bus.mem_read_address = r_pc[5:0];
  assign bus.instr_out        = r_head_data;
  assign bus.instr_pc         = r_head_pc;
  assign bus.instr_valid      = (r_count != 2'd0);
  assign bus.done             = (r_state == ST_DONE);

  // Control FSM: state, program counter and the single outstanding memory read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= 7'd0;
      r_length      <= 7'd0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 6'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc[5:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.run) begin
            r_state  <= ST_FETCH;
            r_pc     <= 7'd0;
            r_length <= bus.program_length;
          end
        end
        ST_FETCH: begin
          if (bus.branch_taken) begin
            r_pc <= {1'b0, bus.branch_target};
          end else if (w_drained) begin
            r_state <= ST_DONE;
          end else if (w_issue) begin
            r_pc <= r_pc + 7'd1;
          end
        end
        ST_DONE: begin
          if (!bus.run) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output buffer: head is presented directly; a branch keeps the pop but drops everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_head_data <= 16'd0;
      r_head_pc   <= 6'd0;
      r_tail_data <= 16'd0;
      r_tail_pc   <= 6'd0;
    end else if (w_branch) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_data <= bus.mem_instruction;
            r_head_pc   <= r_inflight_pc;
          end else begin
            r_tail_data <= bus.mem_instruction;
            r_tail_pc   <= r_inflight_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_data <= r_tail_data;
          r_head_pc   <= r_tail_pc;
          r_count     <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_data <= bus.mem_instruction;
            r_head_pc   <= r_inflight_pc;
          end else begin
            r_head_data <= r_tail_data;
            r_head_pc   <= r_tail_pc;
            r_tail_data <= bus.mem_instruction;
            r_tail_pc   <= r_inflight_pc;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
